// File: rtl/fifo_wptr_full.sv
// Write-side pointer and full/almost-full flags for an async FIFO.
// Optional almost-full logic is built when FIFO_ALMOST_FULL_EN is defined.
module fifo_wptr_full #(
  parameter int ADDR_WIDTH = 4,
  parameter int AFULL_GAP  = 2
) (
  input  logic                  w_clk,
  input  logic                  w_rst,
  input  logic                  w_inc,
  input  logic [ADDR_WIDTH:0]   r_ptr,
  output logic                  w_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH:0]   w_ptr,
  output logic                  w_full,
  output logic                  w_almost_full
);

  localparam int A = ADDR_WIDTH;

  logic [A:0] rq1;
  logic [A:0] rq2;
  logic [A:0] w_bin;
  logic [A:0] w_bin_next;
  logic [A:0] w_gray_next;
  logic [A:0] full_cmp;

  assign w_en        = w_inc & ~w_full & ~w_rst;
  assign w_addr      = w_bin[A-1:0];
  assign w_bin_next  = w_bin + (A+1)'(w_en);
  assign w_gray_next = w_bin_next ^ (w_bin_next >> 1);

  // Full when write is exactly one lap ahead: top two Gray bits inverted.
  assign full_cmp = {~rq2[A:A-1], rq2[A-2:0]};

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      rq1    <= '0;
      rq2    <= '0;
      w_bin  <= '0;
      w_ptr  <= '0;
      w_full <= 1'b0;
    end else begin
      rq1    <= r_ptr;
      rq2    <= rq1;
      w_bin  <= w_bin_next;
      w_ptr  <= w_gray_next;
      w_full <= (w_gray_next == full_cmp);
    end
  end

`ifdef FIFO_ALMOST_FULL_EN
  localparam logic [A:0] AF_LVL = (A+1)'((1 << A) - AFULL_GAP);

  function automatic logic [A:0] gray2bin(input logic [A:0] g);
    logic [A:0] b;
    b[A] = g[A];
    for (int i = A - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [A:0] rq2_bin;
  logic [A:0] level;

  assign rq2_bin = gray2bin(rq2);
  assign level   = w_bin_next - rq2_bin;

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      w_almost_full <= 1'b0;
    end else begin
      w_almost_full <= (level >= AF_LVL);
    end
  end
`else
  assign w_almost_full = 1'b0;
`endif

endmodule
